// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: the NOP encoding used
// for squashed slots, the default reset PC, the fetch FSM states and the
// next-PC source selector.
package pc_fetch_unit_pkg;

  // addi x0, x0, 0 : what IF/ID holds whenever it carries no real instruction
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_TARGET = 2'd1,
    PC_INCR   = 2'd2
  } pc_src_e;

  // Redirect targets are forced to a word boundary; the low two bits are
  // don't-care from EX.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection for the fetch stage. Chooses between the
// aligned redirect target, the sequential PC+4 and holding the current PC.
// All state lives in pc_fetch_unit.
module pc_next_sel
  import pc_fetch_unit_pkg::*;
(
  input  logic        redirect_en_i,  // redirects honoured in this FSM state
  input  logic        advance_en_i,   // sequential advance allowed in this state
  input  logic        pc_sel_i,
  input  logic        stall_i,
  input  logic        busywait_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] target_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] pc_d_o
);

  pc_src_e src;

  // Modulo-2^32 increment: 32'hFFFF_FFFC + 4 wraps to zero by width truncation
  assign pc_plus4_o = pc_i + INSTR_BYTES;

  // Source priority: redirect beats stall, stall beats busywait, then advance
  always_comb begin
    src = PC_HOLD;
    if (redirect_en_i && pc_sel_i) begin
      src = PC_TARGET;
    end else if (advance_en_i && !stall_i && !busywait_i) begin
      src = PC_INCR;
    end
  end

  // Mux the selected source onto the next-PC bus
  always_comb begin
    pc_d_o = pc_i;
    unique case (src)
      PC_TARGET: pc_d_o = word_align(target_i);
      PC_INCR:   pc_d_o = pc_plus4_o;
      default:   pc_d_o = pc_i;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage of the RV32IM pipeline. Owns the PC and the fetch
// address register, issues instruction-memory reads, loads IF/ID, and
// handles EX redirects, load-use stalls and multi-cycle memory.
// Optional build macro: FLUSH_COUNT_EN adds a 32-bit FLUSH_COUNT output
// counting redirect edges.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PC_SEL,
  input  logic [31:0] BRANCH_TARGET,
  input  logic        STALL,
  output logic [31:0] IMEM_ADDRESS,
  output logic        IMEM_READ,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_PC_PLUS4,
  output logic [31:0] IF_ID_INSTR,
  output logic        IF_ID_VALID,
  output logic        FLUSH
`ifdef FLUSH_COUNT_EN
  ,
  output logic [31:0] FLUSH_COUNT
`endif
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic [31:0]  pc_plus4;
  logic [31:0]  imem_addr_q;
  logic         imem_read_q;
  logic [31:0]  ifid_pc_q;
  logic [31:0]  ifid_pc_plus4_q;
  logic [31:0]  ifid_instr_q;
  logic         ifid_valid_q;
  logic         flush_q;
  logic         redirect_en;
  logic         advance_en;
  logic         redirect;

  assign redirect_en = (state_q != IDLE);
  assign advance_en  = (state_q == FETCH);
  assign redirect    = redirect_en && PC_SEL;

  pc_next_sel u_pc_next_sel (
    .redirect_en_i (redirect_en),
    .advance_en_i  (advance_en),
    .pc_sel_i      (PC_SEL),
    .stall_i       (STALL),
    .busywait_i    (IMEM_BUSYWAIT),
    .pc_i          (pc_q),
    .target_i      (BRANCH_TARGET),
    .pc_plus4_o    (pc_plus4),
    .pc_d_o        (pc_d)
  );

  // PC register; the next value already encodes redirect/stall/busy priority
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Fetch FSM with registered memory request, IF/ID register and flush pulse.
  // IMEM_ADDRESS tracks the PC except while a redirected busy read drains in
  // DISCARD, where it must stay on the wrong-path address until the memory
  // completes, then picks up the (possibly re-redirected) PC.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q         <= IDLE;
      imem_addr_q     <= RESET_PC;
      imem_read_q     <= 1'b0;
      ifid_pc_q       <= '0;
      ifid_pc_plus4_q <= '0;
      ifid_instr_q    <= NOP_INSTR;
      ifid_valid_q    <= 1'b0;
      flush_q         <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q     <= FETCH;
          imem_read_q <= 1'b1;
        end

        FETCH: begin
          if (PC_SEL) begin
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
            flush_q      <= 1'b1;
            if (IMEM_BUSYWAIT) begin
              state_q <= DISCARD;
            end else begin
              imem_addr_q <= pc_d;
            end
          end else if (STALL) begin
            // Hold address and IF/ID; the completed read is simply re-issued
          end else if (IMEM_BUSYWAIT) begin
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
          end else begin
            ifid_pc_q       <= pc_q;
            ifid_pc_plus4_q <= pc_plus4;
            ifid_instr_q    <= IMEM_READDATA;
            ifid_valid_q    <= 1'b1;
            imem_addr_q     <= pc_d;
          end
        end

        DISCARD: begin
          if (PC_SEL) begin
            flush_q <= 1'b1;
          end else if (!IMEM_BUSYWAIT) begin
            imem_addr_q <= pc_q;
            state_q     <= FETCH;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef FLUSH_COUNT_EN
  logic [31:0] flush_count_q;

  // Redirect-edge counter, wraps naturally at 2^32
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      flush_count_q <= '0;
    end else if (redirect) begin
      flush_count_q <= flush_count_q + 32'd1;
    end
  end

  assign FLUSH_COUNT = flush_count_q;
`else
  logic unused_redirect;
  assign unused_redirect = redirect;
`endif

  assign IMEM_ADDRESS   = imem_addr_q;
  assign IMEM_READ      = imem_read_q;
  assign IF_ID_PC       = ifid_pc_q;
  assign IF_ID_PC_PLUS4 = ifid_pc_plus4_q;
  assign IF_ID_INSTR    = ifid_instr_q;
  assign IF_ID_VALID    = ifid_valid_q;
  assign FLUSH          = flush_q;

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch stage of the RV32IM pipeline: owns the program counter, drives the instruction memory read port, and loads the IF/ID pipeline register. It consumes the branch/jump decision produced by the branch-detect logic in EX (PC_SEL plus target). On a taken decision it redirects the PC, squashes wrong-path work in IF/ID, and pulses a flush to the ID/EX register. It also honours load-use stalls from the hazard unit and multi-cycle instruction memory (busywait).

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- PC_SEL  input  1  taken branch/jump from EX, sampled at rising edge.
- BRANCH_TARGET  input  32  redirect address; bits [1:0] ignored (treated as 00).
- STALL  input  1  hazard-unit hold for PC and IF/ID.
- IMEM_ADDRESS  output  32  fetch address register.
- IMEM_READ  output  1  read request.
- IMEM_READDATA  input  32  instruction word, valid when IMEM_BUSYWAIT=0.
- IMEM_BUSYWAIT  input  1  memory not ready.
- IF_ID_PC  output  32  PC of the instruction in IF/ID.
- IF_ID_PC_PLUS4  output  32  IF_ID_PC+4.
- IF_ID_INSTR  output  32  instruction in IF/ID; NOP when invalid.
- IF_ID_VALID  output  1  IF/ID holds a real instruction.
- FLUSH  output  1  one-cycle pulse clearing ID/EX on redirect.

## Operation
- States: IDLE, FETCH, DISCARD.
- Reset (async, RESET=0):
  - State IDLE; PC=IMEM_ADDRESS=RESET_PC; IMEM_READ=0.
  - IF_ID_PC=IF_ID_PC_PLUS4=0; IF_ID_INSTR=32'h0000_0013; IF_ID_VALID=0; FLUSH=0.
- IDLE: at the first edge after reset release, go to FETCH. IMEM_READ=1 in FETCH and DISCARD.
- FETCH, per edge, in priority order:
  1. PC_SEL=1: PC and IMEM_ADDRESS <= {BRANCH_TARGET[31:2],2'b00}. IF_ID_VALID<=0, IF_ID_INSTR<=NOP, FLUSH<=1. STALL is ignored. If IMEM_BUSYWAIT=1, go to DISCARD and keep IMEM_ADDRESS at the old address; otherwise stay in FETCH.
  2. STALL=1: hold PC, IMEM_ADDRESS and all IF_ID_*. The read completes and is re-issued.
  3. IMEM_BUSYWAIT=1: hold PC; IF_ID_VALID<=0 and IF_ID_INSTR<=NOP (bubble).
  4. Otherwise: IF_ID <= {PC, PC+4, IMEM_READDATA, valid=1}; PC and IMEM_ADDRESS <= PC+4.
- DISCARD: hold IMEM_ADDRESS on the wrong-path address until IMEM_BUSYWAIT=0. Drop the returned data (IF_ID_VALID stays 0). Then set IMEM_ADDRESS<=PC and go to FETCH.
- PC_SEL=1 in DISCARD: PC<=new target, FLUSH pulses again, stay in DISCARD.
- FLUSH is asserted only in the cycle after a redirect edge.
- Arithmetic: PC+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.

## Timing
- Zero-wait memory: instruction at address A appears in IF/ID one edge after IMEM_ADDRESS=A. Throughput is 1 instruction per cycle.
- Redirect penalty: 2 bubbles (IF/ID squashed plus ID/EX flushed). The target instruction reaches IF/ID at the 2nd edge after the PC_SEL edge, given zero-wait memory.
- Redirect during a busy read: the target fetch starts the cycle after IMEM_BUSYWAIT falls.
- An N-cycle busywait inserts N bubbles.
- Reset asserted mid-operation overrides everything immediately. No pending state survives.

## Configuration
- FLUSH_COUNT_EN defined: adds output FLUSH_COUNT (32-bit). It increments on every redirect edge, wraps modulo 2^32, and resets to 0.
- FLUSH_COUNT_EN undefined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- Shared package: NOP encoding 32'h0000_0013, default RESET_PC, fetch-state enum (IDLE/FETCH/DISCARD).
- One sub-module, pc_next_sel: combinational next-PC selection (target / PC+4 / hold) from PC_SEL, STALL and IMEM_BUSYWAIT. State and registers remain in pc_fetch_unit.

## Test plan
- Reset release, zero-wait memory returning addr+0x100 → IMEM_ADDRESS 0,4,8…; IF_ID_INSTR 0x100,0x104… one edge later; IF_ID_VALID=1 from the 2nd edge after release.
- PC_SEL=1 with BRANCH_TARGET=0x0000_0043 at PC=0x20 → IMEM_ADDRESS=0x40 next cycle; FLUSH=1 exactly one cycle; IF_ID_VALID=0 one cycle; instruction from 0x40 in IF/ID at the following edge.
- STALL=1 for 3 cycles at PC=0x10 → IMEM_ADDRESS and IF_ID_* unchanged for 3 cycles; sequence resumes 0x10→0x14.
- IMEM_BUSYWAIT=1 for 4 cycles on address 0x8, PC_SEL=1 (target 0x80) in the 2nd busy cycle → IMEM_ADDRESS stays 0x8 until busy falls; data dropped; next address 0x80; FLUSH single pulse.
- PC=0xFFFF_FFFC, no stall → next PC 0x0000_0000; IF_ID_PC_PLUS4=0.
- With FLUSH_COUNT_EN: 3 redirects → FLUSH_COUNT=3; RESET low mid-run → 0.
